serpent_round_ctrl: RTL and testbench



---
 rtl/serpent_pkg.sv | 19 +
 rtl/serpent_lt.sv | 30 +++
 rtl/serpent_sbox_bank.sv | 43 ++++
 rtl/serpent_round_ctrl.sv | 121 ++++++++++++
 tb/tb_serpent_round_ctrl.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: FSM encoding, block geometry and word rotate.
package serpent_pkg;

    localparam int unsigned SERPENT_ROUNDS = 32;
    localparam int unsigned BLOCK_W        = 128;

    // Encoding is visible on the optional debug port, so keep values fixed.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFinal = 2'd2,
        StDone  = 2'd3
    } fsm_e;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/serpent_lt.sv
// Serpent linear transform on a 128-bit block; X0 = [127:96], X3 = [31:0].
module serpent_lt
    import serpent_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_block,
    output logic [BLOCK_W-1:0] o_block
);

    logic [31:0] x0, x1, x2, x3;

    // Five mixing steps applied in order; each step sees the previous step's words.
    always_comb begin
        x0 = i_block[127:96];
        x1 = i_block[95:64];
        x2 = i_block[63:32];
        x3 = i_block[31:0];
        x0 = rotl32(x0, 13);
        x2 = rotl32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 1);
        x3 = rotl32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5);
        x2 = rotl32(x2, 22);
        o_block = {x0, x1, x2, x3};
    end

endmodule

// File: rtl/serpent_sbox_bank.sv
// Bitsliced Serpent S-box bank: 32 parallel 4-bit lookups through box i_sel.
// Nibble i is {X3[i], X2[i], X1[i], X0[i]} with X0 as the least significant bit.
module serpent_sbox_bank
    import serpent_pkg::*;
(
    input  logic [2:0]         i_sel,
    input  logic [BLOCK_W-1:0] i_block,
    output logic [BLOCK_W-1:0] o_block
);

    // Entry v of box s sits at SBOX_TBL[s][4*v +: 4].
    localparam logic [63:0] SBOX_TBL [8] = '{
        64'hC90724DEB56A1F83,
        64'h43D68EB1A50972CF,
        64'h25B04E1DFAC39768,
        64'hE57A421D369C8BF0,
        64'hD7E9A4526B0C38F1,
        64'h176D8E30C9A4B25F,
        64'h0A3DF19EB6485C27,
        64'h6539AC47B28E0FD1
    };

    logic [63:0] tbl;
    logic [3:0]  nib;
    logic [3:0]  sub;

    // Gather one bit per word, substitute, scatter back into the same bit lane.
    always_comb begin
        tbl     = SBOX_TBL[i_sel];
        o_block = '0;
        nib     = '0;
        sub     = '0;
        for (int i = 0; i < 32; i++) begin
            nib = {i_block[i], i_block[32+i], i_block[64+i], i_block[96+i]};
            sub = tbl[{nib, 2'b00} +: 4];
            o_block[96+i] = sub[0];
            o_block[64+i] = sub[1];
            o_block[32+i] = sub[2];
            o_block[i]    = sub[3];
        end
    end

endmodule

// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent encryption: one round per clock, then the final subkey XOR.
// Optional debug observation ports are enabled by SERPENT_ROUND_CTRL_DBG_EN.
module serpent_round_ctrl
    import serpent_pkg::*;
#(
    parameter int unsigned ROUNDS     = SERPENT_ROUNDS,
    parameter int unsigned SKEY_IDX_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BLOCK_W-1:0]    i_block,
    output logic                  o_skey_req,
    output logic [SKEY_IDX_W-1:0] o_skey_idx,
    input  logic                  i_skey_vld,
    input  logic [BLOCK_W-1:0]    i_skey,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [BLOCK_W-1:0]    o_block,
    output logic                  o_busy
`ifdef SERPENT_ROUND_CTRL_DBG_EN
    ,
    output logic [SKEY_IDX_W-1:0] o_dbg_round,
    output logic [1:0]            o_dbg_fsm
`endif
);

    localparam logic [SKEY_IDX_W-1:0] LastRound = SKEY_IDX_W'(ROUNDS - 1);
    localparam logic [SKEY_IDX_W-1:0] FinalIdx  = SKEY_IDX_W'(ROUNDS);

    fsm_e                  fsm_q, fsm_d;
    logic [BLOCK_W-1:0]    state_q, state_d;
    logic [SKEY_IDX_W-1:0] round_q, round_d;

    logic [BLOCK_W-1:0] mix;
    logic [BLOCK_W-1:0] sbox_out;
    logic [BLOCK_W-1:0] lt_out;

    assign mix = state_q ^ i_skey;

    serpent_sbox_bank u_sbox (
        .i_sel   (round_q[2:0]),
        .i_block (mix),
        .o_block (sbox_out)
    );

    serpent_lt u_lt (
        .i_block (sbox_out),
        .o_block (lt_out)
    );

    // Next-state: a missing subkey (i_skey_vld low) simply holds everything.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        unique case (fsm_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = i_block;
                    round_d = '0;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                if (i_skey_vld) begin
                    if (round_q == LastRound) begin
                        // Last round skips the LT; round stays put, never wraps.
                        state_d = sbox_out;
                        fsm_d   = StFinal;
                    end else begin
                        state_d = lt_out;
                        round_d = round_q + 1'b1;
                    end
                end
            end
            StFinal: begin
                if (i_skey_vld) begin
                    state_d = mix;
                    fsm_d   = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State, round counter and FSM registers; reset aborts any block in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign o_ready    = (fsm_q == StIdle);
    assign o_valid    = (fsm_q == StDone);
    assign o_busy     = (fsm_q == StRun) || (fsm_q == StFinal);
    assign o_skey_req = o_busy;
    assign o_skey_idx = (fsm_q == StFinal) ? FinalIdx :
                        (fsm_q == StRun)   ? round_q  : '0;
    assign o_block    = state_q;

`ifdef SERPENT_ROUND_CTRL_DBG_EN
    assign o_dbg_round = round_q;
    assign o_dbg_fsm   = fsm_q;
`else
    // Debug observation ports are not present in this build.
`endif

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Self-checking bench for serpent_round_ctrl: 32-round instance plus an 8-round instance.
module tb_serpent_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_block;
    logic         skey_req;
    logic [5:0]   skey_idx;
    logic         skey_vld;
    logic [127:0] skey;
    logic         out_valid;
    logic         ds_ready;
    logic [127:0] out_block;
    logic         busy;

    logic         in_valid8;
    logic         out_ready8;
    logic         skey_req8;
    logic [5:0]   skey_idx8;
    logic [127:0] skey8;
    logic         out_valid8;
    logic [127:0] out_block8;
    logic         busy8;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] skeys[64];

    assign skey  = skeys[skey_idx];
    assign skey8 = skeys[skey_idx8];

    serpent_round_ctrl u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (in_valid),
        .o_ready    (out_ready),
        .i_block    (in_block),
        .o_skey_req (skey_req),
        .o_skey_idx (skey_idx),
        .i_skey_vld (skey_vld),
        .i_skey     (skey),
        .o_valid    (out_valid),
        .i_ready    (ds_ready),
        .o_block    (out_block),
        .o_busy     (busy)
    );

    serpent_round_ctrl #(.ROUNDS(8), .SKEY_IDX_W(6)) u_dut8 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (in_valid8),
        .o_ready    (out_ready8),
        .i_block    (in_block),
        .o_skey_req (skey_req8),
        .o_skey_idx (skey_idx8),
        .i_skey_vld (1'b1),
        .i_skey     (skey8),
        .o_valid    (out_valid8),
        .i_ready    (1'b1),
        .o_block    (out_block8),
        .o_busy     (busy8)
    );

    // Reference S-boxes, entries listed in input order 0..15.
    localparam int SBT [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] m_sbox(input int sel, input logic [127:0] s);
        logic [31:0] w [4];
        logic [31:0] y [4];
        logic [3:0]  v;
        w[0] = s[127:96];
        w[1] = s[95:64];
        w[2] = s[63:32];
        w[3] = s[31:0];
        for (int k = 0; k < 4; k++) y[k] = '0;
        for (int i = 0; i < 32; i++) begin
            v = 4'(SBT[sel][{w[3][i], w[2][i], w[1][i], w[0][i]}]);
            y[0][i] = v[0];
            y[1][i] = v[1];
            y[2][i] = v[2];
            y[3][i] = v[3];
        end
        return {y[0], y[1], y[2], y[3]};
    endfunction

    function automatic logic [127:0] m_lt(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        a = s[127:96];
        b = s[95:64];
        c = s[63:32];
        d = s[31:0];
        a = rl(a, 13);
        c = rl(c, 3);
        b = b ^ a ^ c;
        d = d ^ c ^ (a << 3);
        b = rl(b, 1);
        d = rl(d, 7);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << 7);
        a = rl(a, 5);
        c = rl(c, 22);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] golden(input logic [127:0] pt, input int rounds);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r < rounds; r++) begin
            s = m_sbox(r % 8, s ^ skeys[r]);
            if (r < rounds - 1) s = m_lt(s);
        end
        return s ^ skeys[rounds];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_keys();
        for (int k = 0; k <= 32; k++) skeys[k] = rand128();
    endtask

    // Present one block to the 32-round engine and record its expected ciphertext.
    task automatic accept(input logic [127:0] pt);
        in_block = pt;
        in_valid = 1'b1;
        exp_q.push_back(golden(pt, 32));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b0;
        while (out_valid !== 1'b1) begin
            if (lat >= 200) begin
                timeout = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_ready, out_valid, skey_req, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000", {out_ready, out_valid, skey_req, busy});
        end
        checks++;
        if (skey_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d want 0", skey_idx);
        end
        checks++;
        if (out_block !== 128'd0) begin
            errors++;
            $display("FAIL reset_block: got %h want 0", out_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_block();
        logic [127:0] e;
        for (int k = 0; k < 64; k++) skeys[k] = '0;
        skey_vld = 1'b1;
        checks++;
        if (out_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b want 1", out_ready);
        end
        accept(128'd0);
        for (int c = 1; c <= 33; c++) begin
            checks++;
            if (skey_req !== 1'b1 || skey_idx !== 6'(c - 1) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_seq cycle %0d: req=%b idx=%0d valid=%b want req=1 idx=%0d valid=0",
                         c, skey_req, skey_idx, out_valid, c - 1);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_latency: valid=%b busy=%b want valid=1 busy=0 at 33 cycles",
                     out_valid, busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (out_block !== e) begin
            errors++;
            $display("FAIL zero_block: got %h want %h", out_block, e);
        end
        tick();
        checks++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_return_idle: ready=%b valid=%b want 1 0", out_ready, out_valid);
        end
    endtask

    task automatic test_random();
        logic [127:0] e;
        int           lat;
        bit           to;
        for (int n = 0; n < 1000; n++) begin
            rand_keys();
            accept(rand128());
            wait_valid(lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to || lat != 33) begin
                errors++;
                $display("FAIL random_latency blk %0d: got %0d timeout=%0b want 33", n, lat, to);
                break;
            end
            checks++;
            if (out_block !== e) begin
                errors++;
                $display("FAIL random_block blk %0d: got %h want %h", n, out_block, e);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [127:0] e;
        int           lat;
        int           s5;
        int           s32;
        int           held;
        rand_keys();
        accept(rand128());
        lat  = 0;
        s5   = 3;
        s32  = 2;
        held = -1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (held >= 0) begin
                checks++;
                if (skey_idx !== 6'(held) || skey_req !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: idx=%0d req=%b want idx=%0d req=1",
                             skey_idx, skey_req, held);
                end
            end
            held = -1;
            if (skey_idx == 6'd5 && s5 > 0) begin
                skey_vld = 1'b0;
                s5--;
                held = 5;
            end else if (skey_idx == 6'd32 && s32 > 0) begin
                skey_vld = 1'b0;
                s32--;
                held = 32;
            end else begin
                skey_vld = 1'b1;
            end
            tick();
            lat++;
        end
        skey_vld = 1'b1;
        checks++;
        if (lat != 38 || s5 != 0 || s32 != 0) begin
            errors++;
            $display("FAIL stall_latency: got %0d (left %0d/%0d) want 38", lat, s5, s32);
        end
        e = exp_q.pop_front();
        checks++;
        if (out_block !== e) begin
            errors++;
            $display("FAIL stall_block: got %h want %h", out_block, e);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        logic [127:0] cap;
        int           lat;
        bit           to;
        rand_keys();
        accept(rand128());
        ds_ready = 1'b0;
        wait_valid(lat, to);
        e   = exp_q.pop_front();
        cap = out_block;
        checks++;
        if (to || cap !== e) begin
            errors++;
            $display("FAIL bp_block: got %h timeout=%0b want %h", cap, to, e);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            in_block = rand128();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_block !== e || out_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b block=%h want 1 0 %h",
                         c, out_valid, out_ready, out_block, e);
            end
        end
        in_valid = 1'b0;
        ds_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b want 0 1 0",
                     out_valid, out_ready, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || skey_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored_input: busy=%b req=%b want 0 0", busy, skey_req);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] e;
        int           lat;
        bit           to;
        int           n;
        rand_keys();
        accept(rand128());
        n = 0;
        while (skey_idx !== 6'd17 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (skey_idx !== 6'd17) begin
            errors++;
            $display("FAIL rstmid_reach: idx=%0d want 17", skey_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_ready, out_valid, skey_req, busy} !== 4'b1000 || skey_idx !== 6'd0
            || out_block !== 128'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: flags=%b idx=%0d block=%h want 1000 0 0",
                     {out_ready, out_valid, skey_req, busy}, skey_idx, out_block);
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rand_keys();
        accept(rand128());
        wait_valid(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || lat != 33 || out_block !== e) begin
            errors++;
            $display("FAIL rstmid_next: lat=%0d timeout=%0b got %h want 33 %h",
                     lat, to, out_block, e);
        end
        tick();
    endtask

    task automatic test_rounds8();
        logic [127:0] e;
        logic [127:0] pt;
        rand_keys();
        pt = rand128();
        checks++;
        if (out_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL r8_ready: got %b want 1", out_ready8);
        end
        in_block  = pt;
        in_valid8 = 1'b1;
        exp_q.push_back(golden(pt, 8));
        tick();
        in_valid8 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (skey_idx8 !== 6'(c - 1) || out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL r8_seq cycle %0d: idx=%0d valid=%b want idx=%0d valid=0",
                         c, skey_idx8, out_valid8, c - 1);
            end
            tick();
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid8 !== 1'b1 || out_block8 !== e) begin
            errors++;
            $display("FAIL r8_block: valid=%b got %h want 1 %h", out_valid8, out_block8, e);
        end
        tick();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        in_block  = '0;
        skey_vld  = 1'b1;
        ds_ready  = 1'b1;
        for (int k = 0; k < 64; k++) skeys[k] = '0;
        test_reset();
        test_zero_block();
        test_random();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_rounds8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
